// File: rtl/pool_pkg.sv
// pool_pkg: control codes and state encoding shared by the PoolingALU decoder and pool_seq_ctrl
package pool_pkg;
    localparam logic [3:0] CLR = 4'b1000;
    localparam logic [3:0] NOP = 4'b0000;
    localparam logic [3:0] ACC = 4'b0001;
    localparam logic [3:0] RED = 4'b0010;
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, REDUCE, OUTPUT} state_t;
endpackage

// File: rtl/pool_win_cnt.sv
// pool_win_cnt: loadable down-counter with terminal flag (cnt==0)
// Ports: CLK/RST clock and sync reset; load/ld_val load a start value;
//        dec steps down (holds at 0); cnt current value; term high at 0.
module pool_win_cnt #(
    parameter int N = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [N-1:0] ld_val,
    input  logic         dec,
    output logic [N-1:0] cnt,
    output logic         term
);
    always_ff @(posedge CLK) begin
        if (RST) cnt <= '0;
        else if (load) cnt <= ld_val;
        else if (dec && cnt != '0) cnt <= cnt - N'(1);
    end
    assign term = cnt == '0;
endmodule

// File: rtl/pool_seq_ctrl.sv
// pool_seq_ctrl: KxK max-pooling sequencer driving one PoolingALU column
// Ports: CLK/RST clock and sync reset; start/k_size/n_win job launch;
//        in_valid/in_ready column input handshake; alu_ctrl/alu_max ALU side;
//        out_valid/out_ready/res_data result handshake; busy, done status.
// Optional: POOL_SEQ_PERF_EN adds stall_cnt, a saturating stall-cycle counter.
module pool_seq_ctrl
    import pool_pkg::*;
#(
    parameter int W    = 4,
    parameter int KMAX = 4,
    parameter int NW   = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [2:0]    k_size,
    input  logic [NW-1:0] n_win,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [3:0]    alu_ctrl,
    input  logic [W-1:0]  alu_max,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  res_data,
    output logic          busy,
`ifdef POOL_SEQ_PERF_EN
    output logic [15:0]   stall_cnt,
`endif
    output logic          done
);
    localparam logic [2:0] KM = 3'(KMAX);
    state_t state, nxt;
    logic [2:0] k_reg, col_cnt, red_cnt;
    logic [NW-1:0] n_reg, win_cnt;
    logic clr_hold, col_term, red_term;
    logic go, col_acc, col_last, red_last, win_acc, job_end;
    assign go       = state == IDLE && start;
    assign col_acc  = state == ACCUM && in_valid;
    assign col_last = col_acc && col_term;
    assign red_last = state == REDUCE && red_term;
    assign win_acc  = state == OUTPUT && out_valid && out_ready;
    assign job_end  = win_acc && (win_cnt + NW'(1) == n_reg);
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? CLEAR : IDLE;
            CLEAR:   nxt = ACCUM;
            ACCUM:   nxt = col_last ? REDUCE : ACCUM;
            REDUCE:  nxt = red_term ? OUTPUT : REDUCE;
            OUTPUT:  nxt = win_acc ? (job_end ? IDLE : CLEAR) : OUTPUT;
            default: nxt = IDLE;
        endcase
    end
    // clr_hold keeps the ALU clearing in the cycle right after a reset.
    always_comb begin
        busy     = state != IDLE;
        in_ready = state == ACCUM;
        alu_ctrl = NOP;
        case (state)
            IDLE:    alu_ctrl = clr_hold ? CLR : NOP;
            CLEAR:   alu_ctrl = CLR;
            ACCUM:   alu_ctrl = in_valid ? ACC : NOP;
            REDUCE:  alu_ctrl = RED;
            default: alu_ctrl = NOP;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            clr_hold  <= 1'b1;
            k_reg     <= '0;
            n_reg     <= '0;
            win_cnt   <= '0;
            res_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            clr_hold <= 1'b0;
            done     <= job_end;
            if (go) begin
                k_reg   <= k_size < 3'd2 ? 3'd2 : (k_size > KM ? KM : k_size);
                n_reg   <= n_win;
                win_cnt <= '0;
            end
            if (win_acc) win_cnt <= win_cnt + NW'(1);
            // alu_max already reflects the final reduction during the last RED cycle.
            if (red_last) res_data <= alu_max;
            out_valid <= red_last ? 1'b1 : (win_acc ? 1'b0 : out_valid);
        end
    end
    pool_win_cnt #(.N(3)) u_col (
        .CLK(CLK), .RST(RST), .load(state == CLEAR), .ld_val(k_reg - 3'd1),
        .dec(col_acc), .cnt(col_cnt), .term(col_term)
    );
    pool_win_cnt #(.N(3)) u_red (
        .CLK(CLK), .RST(RST), .load(col_last), .ld_val(k_reg - 3'd2),
        .dec(state == REDUCE), .cnt(red_cnt), .term(red_term)
    );
`ifdef POOL_SEQ_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST || go) stall_cnt <= '0;
        else if (((state == ACCUM && !in_valid) || (state == OUTPUT && out_valid && !out_ready))
                 && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pool_seq_ctrl.sv
// tb_pool_seq_ctrl: directed and table-driven checks of pool_seq_ctrl against a PoolingALU column model
module tb_pool_seq_ctrl;
    localparam logic [3:0] C_CLR = 4'b1000, C_NOP = 4'b0000, C_ACC = 4'b0001, C_RED = 4'b0010;
    logic CLK = 0, RST = 1, start = 0, in_valid = 0, out_ready = 0;
    logic [2:0] k_size = 0;
    logic [7:0] n_win = 0;
    logic in_ready, out_valid, busy, done;
    logic [3:0] alu_ctrl, alu_max, res_data;
`ifdef POOL_SEQ_PERF_EN
    logic [15:0] stall_cnt;
`endif
    int checks = 0, errors = 0;
    always #5 CLK = ~CLK;
    pool_seq_ctrl #(.W(4), .KMAX(4), .NW(8)) dut (
        .CLK(CLK), .RST(RST), .start(start), .k_size(k_size), .n_win(n_win),
        .in_valid(in_valid), .in_ready(in_ready), .alu_ctrl(alu_ctrl), .alu_max(alu_max),
        .out_valid(out_valid), .out_ready(out_ready), .res_data(res_data), .busy(busy),
`ifdef POOL_SEQ_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .done(done)
    );
    // PoolingALU column model: row 0 is the top; max output is the top row's next value.
    logic [3:0] acc [4];
    logic [3:0] ip [4];
    logic [3:0] nx [4];
    logic [3:0] dn [4];
    assign dn[0] = acc[1];
    assign dn[1] = acc[2];
    assign dn[2] = acc[3];
    assign dn[3] = 4'd0;
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nx[i] = acc[i];
            if (alu_ctrl == C_CLR) nx[i] = 4'd0;
            else if (alu_ctrl == C_ACC) nx[i] = ip[i] > acc[i] ? ip[i] : acc[i];
            else if (alu_ctrl == C_RED) nx[i] = dn[i] > acc[i] ? dn[i] : acc[i];
        end
    end
    assign alu_max = nx[0];
    always @(posedge CLK) for (int i = 0; i < 4; i++) acc[i] <= nx[i];

    typedef struct {
        logic st; logic [2:0] k; logic [7:0] n; logic iv; logic ordy;
        logic [3:0] alu; logic ir; logic ov; logic bz; logic dn;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask
    task automatic step();
        @(posedge CLK);
        #1;
    endtask
    task automatic set_ip(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        ip[0] = a; ip[1] = b; ip[2] = c; ip[3] = d;
    endtask
    task automatic apply(input vec_t v, input int i);
        start = v.st; k_size = v.k; n_win = v.n; in_valid = v.iv; out_ready = v.ordy;
        #1;
        chk($sformatf("tbl%0d alu_ctrl", i), alu_ctrl, v.alu);
        chk($sformatf("tbl%0d in_ready", i), in_ready, v.ir);
        chk($sformatf("tbl%0d out_valid", i), out_valid, v.ov);
        chk($sformatf("tbl%0d busy", i), busy, v.bz);
        chk($sformatf("tbl%0d done", i), done, v.dn);
        step();
    endtask

    initial begin
        int dc, ovc, nred, hc, nres, ncol;
        logic [3:0] held, cur;
        int ovq [$];
        logic [3:0] expq [$];
        // K=2, n_win=1, constant in_valid/out_ready: CLR,ACC,ACC,RED,NOP then done
        tbl[0] = '{1, 2, 1, 1, 1, C_NOP, 0, 0, 0, 0};
        tbl[1] = '{0, 2, 1, 1, 1, C_CLR, 0, 0, 1, 0};
        tbl[2] = '{0, 2, 1, 1, 1, C_ACC, 1, 0, 1, 0};
        tbl[3] = '{0, 2, 1, 1, 1, C_ACC, 1, 0, 1, 0};
        tbl[4] = '{0, 2, 1, 1, 1, C_RED, 0, 0, 1, 0};
        tbl[5] = '{0, 2, 1, 1, 1, C_NOP, 0, 1, 1, 0};
        tbl[6] = '{0, 2, 1, 1, 1, C_NOP, 0, 0, 0, 1};
        tbl[7] = '{0, 2, 1, 1, 1, C_NOP, 0, 0, 0, 0};
        set_ip(3, 9, 15, 1);

        // reset state
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst alu_ctrl", alu_ctrl, C_CLR);
            chk("rst busy", busy, 0);
            chk("rst out_valid", out_valid, 0);
            chk("rst in_ready", in_ready, 0);
            chk("rst res_data", res_data, 0);
            chk("rst done", done, 0);
        end
        RST = 0;
        step();
        chk("idle alu_ctrl", alu_ctrl, C_NOP);

        for (int i = 0; i < 8; i++) apply(tbl[i], i);
        chk("k2 res_data", res_data, 9);

        // reset held 3 cycles mid-ACCUM
        start = 1; k_size = 3; n_win = 1; in_valid = 0; out_ready = 1;
        step();
        start = 0;
        step();
        chk("midacc in_ready", in_ready, 1);
        chk("midacc stall alu", alu_ctrl, C_NOP);
        RST = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst alu_ctrl", alu_ctrl, C_CLR);
            chk("midrst busy", busy, 0);
            chk("midrst out_valid", out_valid, 0);
            chk("midrst in_ready", in_ready, 0);
        end
        RST = 0;
        step();

        // K=3, n_win=2, in_valid low on cycles 3 and 4 after start
        dc = -1;
        ovq.delete();
        for (int c = 0; c < 30; c++) begin
            start = c == 0; k_size = 3; n_win = 2; in_valid = !(c == 3 || c == 4); out_ready = 1;
            #1;
            if (c == 3) begin
                chk("stall alu_ctrl", alu_ctrl, C_NOP);
                chk("stall in_ready", in_ready, 1);
            end
            if (out_valid) ovq.push_back(c);
            if (done && dc < 0) dc = c;
            step();
        end
        chk("stall ov count", ovq.size(), 2);
        if (ovq.size() == 2) begin
            chk("stall ov0 cycle", ovq[0], 9);
            chk("stall ov1 cycle", ovq[1], 16);
        end
        chk("stall done cycle", dc, 17);
`ifdef POOL_SEQ_PERF_EN
        chk("stall_cnt in-stall", stall_cnt, 2);
`endif

        // out_ready low 4 cycles in OUTPUT
        start = 1; k_size = 2; n_win = 2; in_valid = 1; out_ready = 0;
        step();
        start = 0;
        repeat (4) step();
        chk("hold ov first", out_valid, 1);
        held = res_data;
        chk("hold res first", held, 9);
        for (int i = 0; i < 4; i++) begin
            chk("hold out_valid", out_valid, 1);
            chk("hold res_data", res_data, held);
            chk("hold alu no clr", alu_ctrl, C_NOP);
            step();
        end
        out_ready = 1;
        #1;
        chk("hold ov accept", out_valid, 1);
        step();
        chk("hold clr after acc", alu_ctrl, C_CLR);
        chk("hold ov cleared", out_valid, 0);
        dc = -1;
        for (int c = 0; c < 20 && dc < 0; c++) begin
            #1;
            if (done) dc = c;
            step();
        end
        chk("hold done seen", dc >= 0, 1);
`ifdef POOL_SEQ_PERF_EN
        chk("stall_cnt out-stall", stall_cnt, 4);
`endif

        // start while busy is ignored
        start = 1; k_size = 2; n_win = 1; in_valid = 1; out_ready = 1;
        step();
        dc = -1;
        for (int c = 1; c < 16; c++) begin
            start = c == 2; k_size = c == 2 ? 3'd4 : 3'd2; n_win = c == 2 ? 8'd5 : 8'd1;
            #1;
            if (done && dc < 0) dc = c;
            step();
        end
        chk("busy start done cycle", dc, 6);
        chk("busy start idle", busy, 0);

        // k_size=7 clamps to KMAX=4
        set_ip(2, 7, 4, 11);
        start = 1; k_size = 7; n_win = 1;
        step();
        start = 0;
        nred = 0; ovc = -1;
        for (int c = 1; c < 20; c++) begin
            #1;
            if (alu_ctrl == C_RED) nred++;
            if (out_valid && ovc < 0) begin
                ovc = c;
                chk("clamp res_data", res_data, 11);
            end
            step();
        end
        chk("clamp red cycles", nred, 3);
        chk("clamp ov cycle", ovc, 9);

        // golden: K=4, n_win=3, random data and handshake stalls
        nres = 0; ncol = 0; cur = 0; dc = -1;
        for (int c = 0; c < 400 && dc < 0; c++) begin
            start = c == 0; k_size = 4; n_win = 3;
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            for (int r = 0; r < 4; r++) ip[r] = 4'($urandom);
            #1;
            if (in_valid && in_ready) begin
                for (int r = 0; r < 4; r++) if (ip[r] > cur) cur = ip[r];
                ncol++;
                if (ncol == 4) begin
                    expq.push_back(cur);
                    cur = 0;
                    ncol = 0;
                end
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("gold unexpected result", 1, 0);
                else chk($sformatf("gold res%0d", nres), res_data, expq.pop_front());
                nres++;
            end
            if (done) dc = c;
            step();
        end
        chk("gold results", nres, 3);
        chk("gold done seen", dc >= 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pool_seq_ctrl.md
Name: pool_seq_ctrl

Overview:
- Sequencer for one column of PoolingALU instances performing KxK max pooling.
- Accepts a column-valid input stream and issues the 4-bit ALU control code each cycle: clear, horizontal accumulate, vertical reduce.
- Presents one pooled result per window on a valid/ready output handshake.
- Sits between the feature-map buffer read port and the PoolingALU column.

Parameters:
- W, 4, ALU data width; used only for passthrough of the result.
- KMAX, 4, largest supported window size.
- NW, 8, width of the window-count register.

Ports:
- CLK  input  1  clock; all logic on posedge.
- RST  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse that begins a job; ignored unless in IDLE.
- k_size  input  3  window size K, legal range 2..KMAX; sampled on start.
- n_win  input  NW  number of windows in the job, nonzero; sampled on start.
- in_valid  input  1  a column of ALU inputs is present this cycle.
- in_ready  output  1  the controller consumes the column this cycle.
- alu_ctrl  output  4  control code to PoolingALU.controlSignal.
- alu_max  input  W  PoolingALU.max from the top ALU of the column.
- out_valid  output  1  res_data holds a pooled result.
- out_ready  input  1  downstream accepts the result.
- res_data  output  W  pooled result.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse after the last window is accepted.

Behaviour:
- Control codes: CLR=4'b1000 (clear accumulators), NOP=4'b0000, ACC=4'b0001 (acc<=max(acc,ip)), RED=4'b0010 (acc<=max(acc,ipFromDown)).
- Reset: state=IDLE, alu_ctrl=CLR, in_ready=0, out_valid=0, res_data=0, busy=0, done=0, all counters 0. RST mid-job aborts immediately; the next cycle is IDLE with the same values.
- State IDLE: alu_ctrl=NOP.
  - On start: latch k_size and n_win, set win_cnt=0, go to CLEAR.
  - k_size outside 2..KMAX is clamped to the nearest legal value.
- State CLEAR: one cycle, alu_ctrl=CLR, go to ACCUM with col_cnt=0.
- State ACCUM: in_ready=1; alu_ctrl=ACC when in_valid, else NOP.
  - Each cycle with in_valid&in_ready increments col_cnt.
  - When col_cnt reaches K-1 on an accepted column, go to REDUCE with red_cnt=0.
  - in_valid low is a stall: no state change, no counter change.
- State REDUCE: alu_ctrl=RED for exactly K-1 cycles, in_ready=0, then go to OUTPUT.
- State OUTPUT: alu_ctrl=NOP.
  - On entry, res_data<=alu_max and out_valid=1 (registered; res_data and out_valid appear the cycle after the last RED).
  - res_data is held stable while out_valid&&!out_ready.
  - On out_valid&&out_ready: out_valid=0, win_cnt++.
    - If win_cnt+1==n_win: done=1 for one cycle, go to IDLE.
    - Otherwise go to CLEAR.
- Latency per window with no stalls: 1 (CLEAR) + K (ACCUM) + (K-1) (REDUCE) + 1 (OUTPUT) cycles until out_valid, i.e. 2K+1.
- start while busy is ignored. Simultaneous start and RST: RST wins.
- win_cnt is NW bits and does not wrap within a job because n_win bounds it.

Optional Feature:
- Macro POOL_SEQ_PERF_EN.
- Defined: adds output stall_cnt [15:0], cleared on start and on RST.
  - Increments once per cycle in which (ACCUM && !in_valid) or (OUTPUT && out_valid && !out_ready).
  - Saturates at 16'hFFFF.
- Not defined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package pool_pkg holds the control-code constants (CLR, NOP, ACC, RED) and the state encoding, so the PoolingALU decoder and this controller share a single definition.
- No sub-module for the FSM.
- One natural sub-module, pool_win_cnt: a loadable down-counter with terminal flag, instantiated for col_cnt and red_cnt.

Test Plan:
- RST held 3 cycles mid-ACCUM -> next cycle state IDLE, alu_ctrl=4'b1000, busy=0, out_valid=0.
- start with K=2, n_win=1, in_valid constant, out_ready=1 -> alu_ctrl sequence CLR,ACC,ACC,RED,NOP; out_valid high 5 cycles after start; done pulses once; then IDLE.
- K=3, n_win=2, in_valid low for 2 cycles during ACCUM -> ACCUM extends by 2 cycles, alu_ctrl=NOP while stalled, two results emitted, stall_cnt=2 when POOL_SEQ_PERF_EN is defined.
- out_ready low 4 cycles in OUTPUT -> res_data stable, out_valid held, no CLR issued until acceptance.
- start pulsed while busy, and k_size=7 at a new start -> the busy-time start is ignored; the new job runs with K=KMAX=4 (REDUCE lasts 3 cycles).
- Golden model: PoolingALU column with random 4-bit data, K=4, n_win=3 -> each res_data equals the max of its 4x4 window.
